ahblite_lcd_ctrl_q: RTL and testbench
=====================================

// Module: ahblite_lcd_ctrl_q
// PURPOSE
//  AHB-Lite slave holding the LCD controller configuration: control bits, one-cycle
//  strobes, N_WIN window register sets (sc/ec/sp/ep) and a command FIFO that feeds
//  the LCD engine through a valid/ready handshake. All registers are readable.
//  CMD writes to a full FIFO stall the bus through HREADYOUT. The block sits
//  between the Cortex-M0 AHB matrix and the LCD timing/ini engine.
// PARAMETERS
//  N_WIN       2   number of window register sets, 1..8
//  FIFO_DEPTH  8   command FIFO entries; power of 2, 2..128
// PORTS
//  HCLK        in   1          bus and block clock
//  HRESET      in   1          synchronous reset, active-high
//  HSEL, HWRITE, HREADY  in  1 each   standard AHB-Lite slave inputs
//  HADDR       in   32         byte address; only HADDR[7:2] is decoded
//  HTRANS      in   2          transfer type; active when HTRANS[1]=1
//  HSIZE, HPROT in  3/4        ignored; all accesses are treated as 32-bit words
//  HWDATA      in   32         write data, sampled in the data phase
//  HREADYOUT   out  1          0 only while a CMD write is stalled
//  HRDATA      out  32         read data, driven in the data phase
//  HRESP       out  1          tied 0
//  lcd_rstn, lcd_en  out  1    control bits CTRL[0], CTRL[1]
//  ini_pulse, color_pulse  out 1   one-cycle strobes
//  win_sc, win_ec, win_sp, win_ep  out  32*N_WIN   window k occupies bits [32k+31:32k]
//  cmd_valid   out  1          FIFO not empty
//  cmd_data    out  32         FIFO head entry
//  cmd_ready   in   1          engine pops the head when cmd_valid && cmd_ready
//  lcd_busy    in   1          engine status, reflected in STATUS[16]
// BEHAVIOUR
//  - Address phase: when HSEL && HTRANS[1] && HREADY, register write/read flag and HADDR[7:2].
//    Data phase: a write uses HWDATA; HRDATA is driven combinationally from the registered address.
//  - Register map (byte offsets):
//    - 0x00 CTRL, RW: [1:0], reset 0.
//    - 0x04 STROBE, WO, reads 0: bit0 -> ini_pulse, bit1 -> color_pulse.
//      Each pulse is high for exactly the cycle after the data-phase cycle.
//    - 0x08 STATUS, RO except bit2:
//      [0] empty, [1] full, [2] sticky pop-underflow, [15:8] level, [16] lcd_busy.
//      Writing 1 to bit2 clears it.
//    - 0x0C CMD, WO, reads 0: pushes HWDATA.
//    - 0x10+16k, k<N_WIN: SC/EC/SP/EP of window k, RW, reset 0.
//    - Unmapped offsets, and windows k>=N_WIN: read 0, writes ignored, no error.
//  - Zero wait states everywhere except the CMD stall case below.
//  - FIFO:
//    - Push occurs in the CMD data phase when !full || pop.
//    - A simultaneous push and pop when full is legal: level is unchanged and the entry is accepted.
//    - Push while full with no pop: HREADYOUT=0 and the data phase is held.
//      The master must hold HWDATA. Retry every cycle until space frees.
//    - Pop on cmd_ready while empty: no effect on the FIFO; sets STATUS[2].
//    - Pointers wrap modulo FIFO_DEPTH. level is 0..FIFO_DEPTH, zero-extended to 8 bits.
//  - Reset values: all outputs and registers 0; FIFO empty (cmd_valid=0); HREADYOUT=1; HRDATA=0.
//  - Reset asserted mid-stall: the pending write is dropped, HREADYOUT returns to 1 and the
//    registered phase is cleared.
//  - The STROBE offset and the CMD offset share no state. Register writes take effect the
//    cycle after the data phase. A read in the cycle after a write returns the new value.
// TESTING
//  - Reset: HRESET for 2 cycles -> every output 0, HREADYOUT=1, STATUS reads 0x0000_0001
//    (lcd_busy=0).
//  - Window: write 0x0000_1234 to 0x20 (window 1 SC) -> win_sc[63:32]=0x1234 next cycle;
//    read back 0x1234. Read of 0x30 with N_WIN=2 -> 0.
//  - Strobe: write 0x3 to 0x04 -> ini_pulse and color_pulse high for exactly 1 cycle.
//  - Fill: cmd_ready=0, push FIFO_DEPTH words 0..7, then push word 8 -> HREADYOUT=0.
//    Assert cmd_ready for 1 cycle -> word 0 popped, word 8 accepted, level stays 8,
//    cmd_data=1.
//  - Underflow: empty FIFO, cmd_ready=1 -> STATUS[2]=1. Write 0x4 to 0x08 -> bit2 cleared.
//  - Reset during stall: HRESET while HREADYOUT=0 -> HREADYOUT=1 and the FIFO is empty
//    next cycle.

Source files
------------

// File: rtl/ahblite_lcd_ctrl_q.sv
// AHB-Lite register slave for the LCD controller: control bits, strobes,
// window register sets and a command FIFO towards the LCD engine.
module ahblite_lcd_ctrl_q #(
    parameter int N_WIN      = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic [31:0]           HWDATA,
    output logic                  HREADYOUT,
    output logic [31:0]           HRDATA,
    output logic                  HRESP,
    output logic                  lcd_rstn,
    output logic                  lcd_en,
    output logic                  ini_pulse,
    output logic                  color_pulse,
    output logic [32*N_WIN-1:0]   win_sc,
    output logic [32*N_WIN-1:0]   win_ec,
    output logic [32*N_WIN-1:0]   win_sp,
    output logic [32*N_WIN-1:0]   win_ep,
    output logic                  cmd_valid,
    output logic [31:0]           cmd_data,
    input  logic                  cmd_ready,
    input  logic                  lcd_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [5:0] A_CTRL   = 6'd0;
    localparam logic [5:0] A_STROBE = 6'd1;
    localparam logic [5:0] A_STATUS = 6'd2;
    localparam logic [5:0] A_CMD    = 6'd3;

    typedef enum logic [1:0] {PH_IDLE, PH_WRITE, PH_READ} phase_t;

    phase_t        phase_q, phase_d;
    logic [5:0]    addr_q;
    logic [1:0]    ctrl_q;
    logic          underflow_q;
    logic [31:0]   win_q [N_WIN][4];
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          empty, full, pop, push, stall, wr_en;
    logic [3:0]    win_idx;
    logic          win_hit;
    logic [31:0]   rdata;
    logic          unused_bits;

    assign unused_bits = ^{HADDR[31:8], HADDR[1:0], HTRANS[0], HSIZE, HPROT};

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(FIFO_DEPTH));
    assign pop     = cmd_ready && !empty;
    assign stall   = (phase_q == PH_WRITE) && (addr_q == A_CMD) && full && !pop;
    assign wr_en   = (phase_q == PH_WRITE) && !stall;
    assign push    = wr_en && (addr_q == A_CMD);
    assign win_idx = addr_q[5:2] - 4'd1;
    assign win_hit = (addr_q[5:2] != 4'd0) && (32'(win_idx) < 32'(N_WIN));

    assign HREADYOUT = !stall;
    assign HRESP     = 1'b0;
    assign HRDATA    = rdata;
    assign lcd_rstn  = ctrl_q[0];
    assign lcd_en    = ctrl_q[1];
    assign cmd_valid = !empty;
    assign cmd_data  = empty ? '0 : mem[rd_ptr];

    for (genvar k = 0; k < N_WIN; k++) begin : g_win
        assign win_sc[32*k +: 32] = win_q[k][0];
        assign win_ec[32*k +: 32] = win_q[k][1];
        assign win_sp[32*k +: 32] = win_q[k][2];
        assign win_ep[32*k +: 32] = win_q[k][3];
    end

    // Data-phase state register.
    always_ff @(posedge HCLK) begin
        if (HRESET) phase_q <= PH_IDLE;
        else        phase_q <= phase_d;
    end

    // Next data phase: accepted address phases only advance while the bus is ready.
    always_comb begin
        phase_d = phase_q;
        if (HREADY) begin
            if (HSEL && HTRANS[1]) phase_d = HWRITE ? PH_WRITE : PH_READ;
            else                   phase_d = PH_IDLE;
        end
    end

    // Latch the word address of an accepted transfer.
    always_ff @(posedge HCLK) begin
        if (HRESET)                          addr_q <= '0;
        else if (HREADY && HSEL && HTRANS[1]) addr_q <= HADDR[7:2];
    end

    // Control, strobe, sticky status and window registers.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ctrl_q      <= '0;
            underflow_q <= 1'b0;
            ini_pulse   <= 1'b0;
            color_pulse <= 1'b0;
            for (int unsigned k = 0; k < N_WIN; k++)
                for (int unsigned j = 0; j < 4; j++)
                    win_q[k][j] <= '0;
        end else begin
            ini_pulse   <= wr_en && (addr_q == A_STROBE) && HWDATA[0];
            color_pulse <= wr_en && (addr_q == A_STROBE) && HWDATA[1];
            if (wr_en && (addr_q == A_CTRL)) ctrl_q <= HWDATA[1:0];
            if (cmd_ready && empty)
                underflow_q <= 1'b1;
            else if (wr_en && (addr_q == A_STATUS) && HWDATA[2])
                underflow_q <= 1'b0;
            for (int unsigned k = 0; k < N_WIN; k++)
                for (int unsigned j = 0; j < 4; j++)
                    if (wr_en && win_hit && (win_idx == 4'(k)) && (addr_q[1:0] == 2'(j)))
                        win_q[k][j] <= HWDATA;
        end
    end

    // FIFO pointers and fill level; push and pop may coincide.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // FIFO storage.
    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr] <= HWDATA;
    end

    // Read-data mux for the current read data phase.
    always_comb begin
        rdata = '0;
        if (phase_q == PH_READ) begin
            case (addr_q)
                A_CTRL:   rdata = {30'd0, ctrl_q};
                A_STATUS: rdata = {15'd0, lcd_busy, 8'(level), 5'd0, underflow_q, full, empty};
                default:  rdata = '0;
            endcase
            for (int unsigned k = 0; k < N_WIN; k++)
                if (win_hit && (win_idx == 4'(k)))
                    rdata = win_q[k][addr_q[1:0]];
        end
    end

endmodule

// File: tb/tb_ahblite_lcd_ctrl_q.sv
// Self-checking bench for ahblite_lcd_ctrl_q: read and command scoreboards.
module tb_ahblite_lcd_ctrl_q;
    localparam int N_WIN      = 2;
    localparam int FIFO_DEPTH = 8;

    logic        HCLK = 1'b0;
    logic        HRESET, HSEL, HWRITE, HREADY;
    logic [31:0] HADDR, HWDATA, HRDATA, cmd_data;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HREADYOUT, HRESP, lcd_rstn, lcd_en, ini_pulse, color_pulse;
    logic [32*N_WIN-1:0] win_sc, win_ec, win_sp, win_ep;
    logic        cmd_valid, cmd_ready, lcd_busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rd_q[$];
    logic [31:0] cmd_q[$];

    assign HREADY = HREADYOUT;

    ahblite_lcd_ctrl_q #(.N_WIN(N_WIN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HWRITE(HWRITE), .HREADY(HREADY),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
        .lcd_rstn(lcd_rstn), .lcd_en(lcd_en), .ini_pulse(ini_pulse), .color_pulse(color_pulse),
        .win_sc(win_sc), .win_ec(win_ec), .win_sp(win_sp), .win_ep(win_ep),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready), .lcd_busy(lcd_busy)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
        int n;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'd0, a};
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        n = 0;
        while (!HREADYOUT && n < 50) begin
            @(posedge HCLK); #1;
            n++;
        end
        check("wr_ready", 32'(HREADYOUT), 32'd1);
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'd0, a};
        rd_q.push_back(exp);
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        check({tag, "_sb"}, 32'(rd_q.size()), 32'd1);
        if (rd_q.size() != 0) check(tag, HRDATA, rd_q.pop_front());
        @(posedge HCLK); #1;
    endtask

    // Start a CMD write and leave it sitting in its data phase.
    task automatic cmd_start(input logic [31:0] d);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0C;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    endtask

    // Engine-side monitor: every handshake pops and compares the command scoreboard.
    always @(negedge HCLK) begin
        if (!HRESET && cmd_valid && cmd_ready) begin
            check("cmd_sb_avail", 32'(cmd_q.size() != 0), 32'd1);
            if (cmd_q.size() != 0) check("cmd_data", cmd_data, cmd_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HWRITE = 1'b0; HADDR = '0; HTRANS = '0;
        HSIZE = 3'd2; HPROT = '0; HWDATA = '0; cmd_ready = 1'b0; lcd_busy = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_hrdata", HRDATA, 32'd0);
        check("rst_hresp", 32'(HRESP), 32'd0);
        check("rst_ctrl_out", 32'({lcd_rstn, lcd_en, ini_pulse, color_pulse}), 32'd0);
        check("rst_win", 32'(|{win_sc, win_ec, win_sp, win_ep}), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_data", cmd_data, 32'd0);
        ahb_read(8'h08, 32'h0000_0001, "rst_status");
        ahb_read(8'h00, 32'h0, "rst_ctrl");

        lcd_busy = 1'b1;
        ahb_read(8'h08, 32'h0001_0001, "status_busy");
        lcd_busy = 1'b0;

        ahb_write(8'h00, 32'hFFFF_FFFF);
        check("ctrl_rstn", 32'(lcd_rstn), 32'd1);
        check("ctrl_en", 32'(lcd_en), 32'd1);
        ahb_read(8'h00, 32'h3, "ctrl_rd");
        ahb_write(8'h00, 32'h2);
        check("ctrl_rstn0", 32'(lcd_rstn), 32'd0);
        check("ctrl_en1", 32'(lcd_en), 32'd1);

        ahb_write(8'h20, 32'h0000_1234);
        check("win1_sc", win_sc[63:32], 32'h0000_1234);
        check("win0_sc", win_sc[31:0], 32'h0);
        ahb_read(8'h20, 32'h0000_1234, "win1_sc_rd");
        ahb_write(8'h1C, 32'hABCD_0001);
        check("win0_ep", win_ep[31:0], 32'hABCD_0001);
        ahb_read(8'h1C, 32'hABCD_0001, "win0_ep_rd");
        ahb_write(8'h30, 32'hFFFF_FFFF);
        ahb_read(8'h30, 32'h0, "win2_unmapped");
        ahb_read(8'h40, 32'h0, "unmapped_40");
        check("win_untouched", win_sc[63:32] ^ win_ec[63:32], 32'h0000_1234);

        ahb_write(8'h04, 32'h3);
        check("strobe_ini_hi", 32'(ini_pulse), 32'd1);
        check("strobe_col_hi", 32'(color_pulse), 32'd1);
        @(posedge HCLK); #1;
        check("strobe_ini_lo", 32'(ini_pulse), 32'd0);
        check("strobe_col_lo", 32'(color_pulse), 32'd0);
        ahb_write(8'h04, 32'h1);
        check("strobe_ini_only", 32'({ini_pulse, color_pulse}), 32'h2);
        ahb_read(8'h04, 32'h0, "strobe_rd");

        // Fill the FIFO, then stall on the extra word.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            ahb_write(8'h0C, 32'(i));
            cmd_q.push_back(32'(i));
        end
        ahb_read(8'h08, 32'h0000_0802, "status_full");
        ahb_read(8'h0C, 32'h0, "cmd_rd");
        cmd_start(32'd8);
        check("stall_0", 32'(HREADYOUT), 32'd0);
        @(posedge HCLK); #1;
        check("stall_1", 32'(HREADYOUT), 32'd0);
        cmd_ready = 1'b1;
        #1;
        check("stall_release", 32'(HREADYOUT), 32'd1);
        cmd_q.push_back(32'd8);
        @(posedge HCLK); #1;
        cmd_ready = 1'b0;
        check("head_after_pop", cmd_data, 32'd1);
        check("valid_after_pop", 32'(cmd_valid), 32'd1);
        ahb_read(8'h08, 32'h0000_0802, "level_stays_full");

        // Drain, then keep ready high on an empty FIFO.
        cmd_ready = 1'b1;
        for (int i = 0; i < 20 && cmd_q.size() != 0; i++) begin
            @(posedge HCLK); #1;
        end
        check("drain_left", 32'(cmd_q.size()), 32'd0);
        repeat (2) @(posedge HCLK);
        #1;
        cmd_ready = 1'b0;
        check("drain_valid", 32'(cmd_valid), 32'd0);
        ahb_read(8'h08, 32'h0000_0005, "underflow_set");
        ahb_write(8'h08, 32'h0000_0004);
        ahb_read(8'h08, 32'h0000_0001, "underflow_clr");

        // Reset while a CMD write is stalled.
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            ahb_write(8'h0C, 32'h100 + 32'(i));
            cmd_q.push_back(32'h100 + 32'(i));
        end
        cmd_start(32'h1FF);
        check("rst_stall", 32'(HREADYOUT), 32'd0);
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        cmd_q.delete();
        check("rst_stall_ready", 32'(HREADYOUT), 32'd1);
        check("rst_stall_empty", 32'(cmd_valid), 32'd0);
        check("rst_stall_ctrl", 32'(lcd_en), 32'd0);
        check("rst_stall_win", win_sc[63:32], 32'd0);
        ahb_read(8'h08, 32'h0000_0001, "rst_stall_status");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
